// File: rtl/matvec_row_sequencer_if.sv
// Job, result and shared inner-product signals of matvec_row_sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface matvec_row_sequencer_if #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int PW = 2*DW + $bits(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW*N*M-1:0]     matrix_inp;
  logic [DW*N-1:0]       vector_inp;
  logic [DW*N-1:0]       ip_inp1;
  logic [DW*N-1:0]       ip_inp2;
  logic [PW-1:0]         ip_outp;
  logic                  out_valid;
  logic                  out_ready;
  logic [PW*M-1:0]       outp;
  logic                  busy;

  modport master (
    output in_valid, matrix_inp, vector_inp, ip_outp, out_ready,
    input  in_ready, ip_inp1, ip_inp2, out_valid, outp, busy
  );

  modport slave (
    input  in_valid, matrix_inp, vector_inp, ip_outp, out_ready,
    output in_ready, ip_inp1, ip_inp2, out_valid, outp, busy
  );
endinterface

// File: rtl/matvec_row_sequencer.sv
// Time-multiplexes one external inner-product unit over the M rows of a
// latched matrix-vector job and gathers the dot products into one result.
module matvec_row_sequencer #(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int IP_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matvec_row_sequencer_if.slave  seq_if
);
  localparam int PW = 2*DW + $bits(N);
  localparam int RW = DW*N;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q;
  logic [M-1:0][RW-1:0]   mat_q;
  logic [RW-1:0]          ip_inp1_q;
  logic [RW-1:0]          ip_inp2_q;
  logic [M-1:0][PW-1:0]   outp_q;
  logic [IW-1:0]          issue_cnt_q;
  logic [CW-1:0]          cap_cnt_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [M-1:0][RW-1:0]   mat_in_s;
  logic                   issue_s;
  logic                   last_issue_s;
  logic                   cap_v_s;
  logic [IW-1:0]          cap_idx_s;
  logic                   last_cap_s;
  logic [IW-1:0]          next_row_s;

  assign mat_in_s     = seq_if.matrix_inp;
  assign issue_s      = (state_q == S_RUN);
  assign last_issue_s = (issue_cnt_q == IW'(M - 1));
  assign next_row_s   = issue_cnt_q + IW'(1);
  assign last_cap_s   = cap_v_s && (cap_cnt_q == CW'(M - 1));

  // The capture for a row lands IP_LAT edges after its issue cycle ends.
  generate
    if (IP_LAT == 0) begin : g_comb_ip
      assign cap_v_s   = issue_s;
      assign cap_idx_s = issue_cnt_q;
    end else begin : g_tag_pipe
      logic [IP_LAT-1:0]          tag_v_q;
      logic [IP_LAT-1:0][IW-1:0]  tag_idx_q;

      // Tag pipe: issue-valid plus row index, matching the unit's latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_v_q   <= '0;
          tag_idx_q <= '0;
        end else begin
          tag_v_q[0]   <= issue_s;
          tag_idx_q[0] <= issue_cnt_q;
          for (int i = 1; i < IP_LAT; i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
          end
        end
      end

      assign cap_v_s   = tag_v_q[IP_LAT-1];
      assign cap_idx_s = tag_idx_q[IP_LAT-1];
    end
  endgenerate

  // Job FSM with registered handshake flags, issue and capture bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mat_q       <= '0;
      ip_inp1_q   <= '0;
      ip_inp2_q   <= '0;
      outp_q      <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (cap_v_s) begin
        outp_q[cap_idx_s] <= seq_if.ip_outp;
        cap_cnt_q         <= cap_cnt_q + CW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (seq_if.in_valid) begin
            mat_q       <= mat_in_s;
            ip_inp1_q   <= mat_in_s[0];
            ip_inp2_q   <= seq_if.vector_inp;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_issue_s) begin
            ip_inp1_q <= '0;
            if (last_cap_s) begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q     <= S_WAIT;
            end
          end else begin
            issue_cnt_q <= next_row_s;
            ip_inp1_q   <= mat_q[next_row_s];
          end
        end
        S_WAIT: begin
          if (last_cap_s) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // A job offered on the handshake edge waits for the IDLE cycle.
          if (seq_if.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign seq_if.in_ready  = in_ready_q;
  assign seq_if.out_valid = out_valid_q;
  assign seq_if.busy      = busy_q;
  assign seq_if.ip_inp1   = ip_inp1_q;
  assign seq_if.ip_inp2   = ip_inp2_q;
  assign seq_if.outp      = outp_q;

endmodule

// File: doc/matvec_row_sequencer.md
Name: matvec_row_sequencer

Overview:
- Time-multiplexes a single external inner-product datapath across the M rows of a matrix-vector job.
- Accepts one matrix+vector job per valid/ready handshake and latches it.
- Issues one row per cycle to the shared datapath and collects each dot product into the matching output slice.
- Presents the full M-element result with its own valid/ready handshake. Replaces M parallel inner-product instances when area matters more than throughput.

Parameters:
- M, 4, matrix rows = number of result elements
- N, 4, matrix columns = vector length
- DW, 8, element width of matrix and vector entries
- IP_LAT, 0, cycles of pipeline latency of the external inner-product unit (0 = combinational)
- PW (localparam), 2*DW+$bits(N), width of one dot product; same convention as the inner-product unit output

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  sequencer can accept a job
- matrix_inp  in  DW*N*M  row i occupies bits [DW*N*(i+1)-1 : DW*N*i]
- vector_inp  in  DW*N  operand vector
- ip_inp1  out  DW*N  row currently issued to the inner-product unit
- ip_inp2  out  DW*N  latched vector to the inner-product unit
- ip_outp  in  PW  dot product returned by the inner-product unit
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- outp  out  PW*M  element i at bits [PW*(i+1)-1 : PW*i]
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, outp = 0, ip_inp1 = 0, ip_inp2 = 0, issue/capture counters = 0, latency tag pipe cleared.
- States:
  - IDLE: in_ready = 1. An edge with in_valid & in_ready latches matrix_inp and vector_inp into internal registers and moves to RUN. Inputs may change freely after that edge.
  - RUN: issues row k, k = 0..M-1, in the k-th cycle after the accepting edge. ip_inp1 = latched row k; ip_inp2 = latched vector. After row M-1 is issued: go to WAIT if IP_LAT > 0, otherwise to DONE once the last capture completes.
  - WAIT: ip_inp1 = 0. Stays here until all M results are captured, then goes to DONE.
  - DONE: out_valid = 1, and outp is held stable. An edge with out_valid & out_ready returns to IDLE.
- Capture: a tag pipe of depth IP_LAT carries issue-valid plus row index. ip_outp is sampled into outp slice k at the clock edge ending cycle (issue cycle of row k + IP_LAT).
  - With IP_LAT = 0, capture happens at the edge ending the issue cycle.
  - The sequencer performs no arithmetic. ip_outp is stored verbatim at width PW, with no truncation or sign handling.
- Latency: out_valid rises M+IP_LAT edges after the accepting edge. Throughput is one job per M+IP_LAT+2 cycles minimum; there is no overlap between jobs.
- Control-flag rules:
  - in_ready = 0 in RUN, WAIT and DONE.
  - A new job offered during the same cycle as the output handshake is not accepted until the following IDLE cycle.
  - busy = 1 in RUN, WAIT and DONE.
- Boundaries:
  - M = 1: RUN lasts one cycle.
  - out_ready held low: DONE persists indefinitely, with outp and out_valid unchanged.
  - out_ready high before out_valid has no effect.
  - outp retains the previous job's result in IDLE and is overwritten slice-by-slice during the next job.
- Reset mid-operation (any state): immediate return to reset values. The partial result and the in-flight tags are discarded, and no out_valid is produced for the aborted job.

Test Plan:
- IP_LAT=0, M=N=4, DW=8, matrix = identity, vector = {4,3,2,1} (element0 = 1):
  - outp slices 0..3 = 1, 2, 3, 4.
  - out_valid rises 4 edges after accept.
  - ip_inp1 shows rows 0..3 in consecutive cycles.
- IP_LAT=2, external 2-stage registered inner-product model, all-255 matrix and vector: every slice = 260100 (0x3F804), and out_valid rises 6 edges after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and changing inputs throughout.
  - in_ready stays 0 and outp stays stable.
  - Then pulse out_ready: IDLE follows, and the next job is accepted one cycle later.
- Input latching: change matrix_inp/vector_inp every cycle after the accept edge. The result matches only the values present at the accept edge.
- Reset mid-run: assert rst_n low during row 2 of RUN (IP_LAT=2).
  - All outputs return to reset values asynchronously.
  - After release, a new job completes correctly with no stale captures from the aborted tags.
- Back-to-back jobs with in_valid and out_ready held high:
  - Each result is correct.
  - Consecutive accepts are spaced M+IP_LAT+2 cycles apart.
  - busy is low exactly one cycle between jobs.
